print_board_fmt: RTL
====================

Name: print_board_fmt

Overview:
Parametrised successor to print_board. It renders an ROWS x COLS two-player board as ASCII text over the existing uart_tx byte interface. Added features: optional '|' cell separators and '-+-' rule lines between rows, selectable CRLF or LF line ending, a per-cell highlight mask, a conflict glyph, and a done pulse. It sits between the game controller and uart_tx.

Parameters:
ROWS, 3, board rows (1..15)
COLS, 3, board columns (1..15)
SEP, 1, 1 = '|' between cells and a rule line between rows; 0 = bare cells
CRLF, 1, 1 = end each line with 8'h0D 8'h0A; 0 = end with 8'h0A only
CHAR_A, 8'h4F, glyph for a player-A cell ('O')
CHAR_B, 8'h58, glyph for a player-B cell ('X')
CHAR_EMPTY, 8'h2E, glyph for an empty cell ('.')
CHAR_BOTH, 8'h23, glyph when both players' bits are set ('#')

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr  in  1  start request; accepted only while ready=1
board_a  in  ROWS*COLS  player A occupancy; bit r*COLS+c is row r, column c; bit 0 is top-left
board_b  in  ROWS*COLS  player B occupancy, same indexing
hl_mask  in  ROWS*COLS  highlight mask, same indexing
ready  out  1  idle and able to accept wr
done  out  1  one-cycle pulse when the last byte has been issued
uart_wr  out  1  one-cycle byte strobe to uart_tx
uart_din  out  8  byte to send; valid while uart_wr=1
uart_ready  in  1  uart_tx idle

Behaviour:
- Reset: ready=1, done=0, uart_wr=0, uart_din=8'h00. The FSM returns to IDLE. Reset wins over any simultaneous wr, and a print in progress is abandoned with no further strobes.
- Start: a cycle with wr=1 and ready=1 latches board_a, board_b and hl_mask. ready drops on the next cycle. Later input changes do not affect the output. wr while ready=0 is ignored.
- States: IDLE, CELL, VBAR, CR, LF, RULE.
- Line order for each row r: COLS cell glyphs, with one '|' (8'h7C) between adjacent cells if SEP=1, then EOL.
- EOL is CR then LF if CRLF=1, otherwise LF only.
- If SEP=1 and r<ROWS-1, the row's EOL is followed by a rule line and another EOL. The rule line is 2*COLS-1 bytes: '-' (8'h2D) at even positions, '+' (8'h2B) at odd positions.
- Cell glyph: a&~b gives CHAR_A; ~a&b gives CHAR_B; ~a&~b gives CHAR_EMPTY; a&b gives CHAR_BOTH.
- If the hl bit is set and the cell is A-only or B-only, the glyph is OR'd with 8'h20 (lowercase). Highlight has no effect on empty or conflict cells.
- Total bytes = ROWS*(COLS + SEP*(COLS-1) + 1+CRLF) + SEP*(ROWS-1)*(2*COLS-1 + 1+CRLF).
- Byte handshake: uart_wr is asserted for exactly one cycle, with uart_din valid that cycle, only when uart_ready=1.
- The cycle after each strobe is a guard cycle: uart_ready is ignored and no strobe is issued.
- Strobes are therefore at least 2 cycles apart. uart_tx must drop ready within 1 cycle of wr.
- uart_ready held low stalls the FSM indefinitely without loss.
- Finish: the cycle after the final strobe, done=1 for one cycle and ready=1 in the same cycle. A wr in that cycle starts a new print.
- Counters: row counter is $clog2(ROWS) bits and position counter is $clog2(2*COLS) bits. Both wrap to 0 at row/line end. There is no arithmetic overflow for the parameter ranges above.

Decomposition:
- Package print_board_pkg holds:
  - the state enum;
  - ASCII constants (CR, LF, VBAR, DASH, PLUS);
  - the localparam function for total byte count, which the bench also uses.
- One combinational sub-module, board_cell_glyph, takes (a, b, hl) and returns the 8-bit glyph and carries the CHAR_* parameters.
- The FSM and counters stay in print_board_fmt.

Test Plan:
1. Defaults, board_a=9'b100010001, board_b=9'b010101010, hl=0, wr pulse -> exactly 35 bytes "O|X|.\r\n-+-+-\r\nX|O|X\r\n-+-+-\r\n.|X|O\r\n". done pulses once, and ready=1 on the same cycle.
2. ROWS=4, COLS=4, SEP=0, CRLF=0, all-empty board -> 20 bytes "....\n" x4, with no '|' and no rule lines.
3. Same boards as test 1, hl_mask=9'b100010001 -> row lines "o|X|.", "X|o|X", ".|X|o". Setting board_a[2]=board_b[2]=1 gives a '#' at row 0, column 2 of the first line.
4. Toggle board_a and assert wr repeatedly after acceptance -> output identical to test 1 and only one done pulse. Drive wr with ready=0 -> no effect.
5. Hold uart_ready=0 for 1000 cycles mid-print -> uart_wr stays 0. On release, the byte stream resumes with no drop or duplicate, and strobes are always at least 2 cycles apart.
6. Assert reset after the 10th byte -> uart_wr=0 and ready=1 from the next cycle. A new wr restarts from byte 'O' and yields the full 35 bytes.

Source files
------------

// File: rtl/print_board_pkg.sv
// print_board_pkg: shared definitions for the board printer.
//   state_t      - FSM states of print_board_fmt
//   ASCII_*      - fixed punctuation bytes used in the text rendering
//   total_bytes  - number of bytes one print emits for a given geometry
package print_board_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CELL,
        ST_VBAR,
        ST_CR,
        ST_LF,
        ST_RULE
    } state_t;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_VBAR = 8'h7C;
    localparam logic [7:0] ASCII_DASH = 8'h2D;
    localparam logic [7:0] ASCII_PLUS = 8'h2B;

    // Cell lines plus (when separators are on) the rule lines between rows.
    function automatic int total_bytes(input int rows, input int cols,
                                       input int sep, input int crlf);
        return rows * (cols + sep * (cols - 1) + 1 + crlf)
             + sep * (rows - 1) * (2 * cols - 1 + 1 + crlf);
    endfunction

endpackage

// File: rtl/board_cell_glyph.sv
// board_cell_glyph: combinational mapping of one board cell to its glyph.
//   a, b   - player A / player B occupancy of the cell
//   hl     - highlight; lowercases single-owner glyphs
//   glyph  - 8-bit ASCII byte to print
module board_cell_glyph #(
    parameter logic [7:0] CHAR_A     = 8'h4F,
    parameter logic [7:0] CHAR_B     = 8'h58,
    parameter logic [7:0] CHAR_EMPTY = 8'h2E,
    parameter logic [7:0] CHAR_BOTH  = 8'h23
) (
    input  logic       a,
    input  logic       b,
    input  logic       hl,
    output logic [7:0] glyph
);

    always_comb begin
        glyph = CHAR_EMPTY;
        case ({a, b})
            2'b10:   glyph = CHAR_A | (hl ? 8'h20 : 8'h00);
            2'b01:   glyph = CHAR_B | (hl ? 8'h20 : 8'h00);
            2'b11:   glyph = CHAR_BOTH;
            default: glyph = CHAR_EMPTY;
        endcase
    end

endmodule

// File: rtl/print_board_fmt.sv
// print_board_fmt: renders a ROWS x COLS two-player board as ASCII over a
// uart_tx byte interface.
//   clk, reset         - clock, synchronous active-high reset
//   wr                 - start request, accepted while ready=1
//   board_a/b, hl_mask - occupancy and highlight, bit r*COLS+c, latched on start
//   ready              - idle, wr will be accepted
//   done               - one-cycle pulse the cycle after the final byte
//   uart_wr, uart_din  - byte strobe and data to uart_tx
//   uart_ready         - uart_tx idle
module print_board_fmt
    import print_board_pkg::*;
#(
    parameter int         ROWS       = 3,
    parameter int         COLS       = 3,
    parameter int         SEP        = 1,
    parameter int         CRLF       = 1,
    parameter logic [7:0] CHAR_A     = 8'h4F,
    parameter logic [7:0] CHAR_B     = 8'h58,
    parameter logic [7:0] CHAR_EMPTY = 8'h2E,
    parameter logic [7:0] CHAR_BOTH  = 8'h23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic [ROWS*COLS-1:0] board_a,
    input  logic [ROWS*COLS-1:0] board_b,
    input  logic [ROWS*COLS-1:0] hl_mask,
    output logic                 ready,
    output logic                 done,
    output logic                 uart_wr,
    output logic [7:0]           uart_din,
    input  logic                 uart_ready
);

    localparam int N  = ROWS * COLS;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW = $clog2(2 * COLS);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t         state, state_nx;
    logic [RW-1:0]  row, row_nx;
    logic [PW-1:0]  pos, pos_nx;
    logic           in_rule, in_rule_nx;   // current EOL terminates a rule line
    logic           guard;                 // cycle after a strobe
    logic           latch, last;
    logic [N-1:0]   la, lb, lh;
    logic [IW-1:0]  idx;
    logic [7:0]     glyph;
    logic [7:0]     din;

    assign ready    = (state == ST_IDLE);
    assign uart_wr  = (state != ST_IDLE) && !guard && uart_ready && !reset;
    assign uart_din = din;

    // Position counts cells while in a cell line, bytes while in a rule line.
    assign idx = IW'(row) * IW'(COLS) + IW'(pos);

    board_cell_glyph #(
        .CHAR_A(CHAR_A), .CHAR_B(CHAR_B),
        .CHAR_EMPTY(CHAR_EMPTY), .CHAR_BOTH(CHAR_BOTH)
    ) u_glyph (
        .a(la[idx]), .b(lb[idx]), .hl(lh[idx]), .glyph(glyph)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            row     <= '0;
            pos     <= '0;
            in_rule <= 1'b0;
            guard   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            row     <= row_nx;
            pos     <= pos_nx;
            in_rule <= in_rule_nx;
            guard   <= uart_wr;
            done    <= last;
        end
    end

    // Board snapshot only; no reset needed since it is reloaded on every start.
    always_ff @(posedge clk) begin
        if (latch) begin
            la <= board_a;
            lb <= board_b;
            lh <= hl_mask;
        end
    end

    always_comb begin
        state_nx   = state;
        row_nx     = row;
        pos_nx     = pos;
        in_rule_nx = in_rule;
        latch      = 1'b0;
        last       = 1'b0;
        din        = 8'h00;
        case (state)
            ST_IDLE: begin
                if (wr && !reset) begin
                    latch      = 1'b1;
                    state_nx   = ST_CELL;
                    row_nx     = '0;
                    pos_nx     = '0;
                    in_rule_nx = 1'b0;
                end
            end
            ST_CELL: begin
                din = glyph;
                if (uart_wr) begin
                    if (pos == PW'(COLS - 1)) begin
                        pos_nx   = '0;
                        state_nx = (CRLF != 0) ? ST_CR : ST_LF;
                    end else begin
                        pos_nx   = pos + 1'b1;
                        state_nx = (SEP != 0) ? ST_VBAR : ST_CELL;
                    end
                end
            end
            ST_VBAR: begin
                din = ASCII_VBAR;
                if (uart_wr) state_nx = ST_CELL;
            end
            ST_CR: begin
                din = ASCII_CR;
                if (uart_wr) state_nx = ST_LF;
            end
            ST_LF: begin
                din = ASCII_LF;
                if (uart_wr) begin
                    if (in_rule) begin
                        in_rule_nx = 1'b0;
                        row_nx     = row + 1'b1;
                        state_nx   = ST_CELL;
                    end else if (row == RW'(ROWS - 1)) begin
                        last     = 1'b1;
                        row_nx   = '0;
                        state_nx = ST_IDLE;
                    end else if (SEP != 0) begin
                        state_nx = ST_RULE;
                    end else begin
                        row_nx   = row + 1'b1;
                        state_nx = ST_CELL;
                    end
                end
            end
            ST_RULE: begin
                din = pos[0] ? ASCII_PLUS : ASCII_DASH;
                if (uart_wr) begin
                    if (pos == PW'(2 * COLS - 2)) begin
                        pos_nx     = '0;
                        in_rule_nx = 1'b1;
                        state_nx   = (CRLF != 0) ? ST_CR : ST_LF;
                    end else begin
                        pos_nx = pos + 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule
